// File: rtl/stopwatch_display.sv
// Multiplexed 8-digit MM.SS.mmm seven-segment driver. A shared serial double-dabble
// engine converts a coherent snapshot of ms/sec/min to BCD every 32 cycles.
module stopwatch_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] millisec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic       blank,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [2:0] {CAPTURE, CONV_MS, CONV_SEC, CONV_MIN, COMMIT} state_t;

  state_t        state, state_next;
  logic [3:0]    bit_cnt;
  logic          last_bit;
  logic [5:0]    sec_cap, min_cap;
  logic [9:0]    bin;
  logic [11:0]   bcd;
  logic [11:0]   bcd_adj;
  logic [21:0]   shifted;
  logic [27:0]   shadow;   // {min[7:0], sec[7:0], ms[11:0]} as BCD
  logic [27:0]   disp;
  logic          capture_en, step_en, store_ms, store_sec, store_min, commit_en;
  logic [CW-1:0] scan_cnt;
  logic [2:0]    idx;
  logic [3:0]    digit;

  assign last_bit = (bit_cnt == 4'd9);

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0: decode = 7'h40;
      4'd1: decode = 7'h79;
      4'd2: decode = 7'h24;
      4'd3: decode = 7'h30;
      4'd4: decode = 7'h19;
      4'd5: decode = 7'h12;
      4'd6: decode = 7'h02;
      4'd7: decode = 7'h78;
      4'd8: decode = 7'h00;
      4'd9: decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  // One double-dabble iteration: add 3 to each nibble >= 5, then shift {bcd,bin}.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin} << 1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CAPTURE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CAPTURE:  state_next = CONV_MS;
      CONV_MS:  if (last_bit) state_next = CONV_SEC;
      CONV_SEC: if (last_bit) state_next = CONV_MIN;
      CONV_MIN: if (last_bit) state_next = COMMIT;
      COMMIT:   state_next = CAPTURE;
      default:  state_next = CAPTURE;
    endcase
  end

  // NOTE: every control signal gets a default first so the case cannot infer a latch.
  always_comb begin
    capture_en = 1'b0;
    step_en    = 1'b0;
    store_ms   = 1'b0;
    store_sec  = 1'b0;
    store_min  = 1'b0;
    commit_en  = 1'b0;
    case (state)
      CAPTURE:  capture_en = 1'b1;
      CONV_MS:  begin step_en = 1'b1; store_ms  = last_bit; end
      CONV_SEC: begin step_en = 1'b1; store_sec = last_bit; end
      CONV_MIN: begin step_en = 1'b1; store_min = last_bit; end
      COMMIT:   commit_en = 1'b1;
      default:  ;
    endcase
  end

  // NOTE: shadow and display registers are reset so the first frame reads 00.00.000.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      sec_cap <= '0;
      min_cap <= '0;
      bin     <= '0;
      bcd     <= '0;
      shadow  <= '0;
      disp    <= '0;
    end else begin
      if (capture_en) begin
        bin     <= (millisec > 10'd999) ? 10'd999 : millisec;
        sec_cap <= (sec > 6'd59) ? 6'd59 : sec;
        min_cap <= (min > 6'd59) ? 6'd59 : min;
        bcd     <= '0;
        bit_cnt <= '0;
      end
      if (step_en) begin
        bcd     <= shifted[21:10];
        bin     <= shifted[9:0];
        bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
      end
      // The next field is loaded with a cleared accumulator as the current one completes.
      if (store_ms) begin
        shadow[11:0] <= shifted[21:10];
        bin          <= {4'd0, sec_cap};
        bcd          <= '0;
      end
      if (store_sec) begin
        shadow[19:12] <= shifted[17:10];
        bin           <= {4'd0, min_cap};
        bcd           <= '0;
      end
      if (store_min) shadow[27:20] <= shifted[17:10];
      if (commit_en) disp <= shadow;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    digit = 4'd0;
    case (idx)
      3'd0: digit = disp[3:0];
      3'd1: digit = disp[7:4];
      3'd2: digit = disp[11:8];
      3'd3: digit = disp[15:12];
      3'd4: digit = disp[19:16];
      3'd5: digit = disp[23:20];
      3'd6: digit = disp[27:24];
      default: digit = 4'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else if (blank || idx == 3'd7) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= ~(8'b1 << idx);
      seg <= decode(digit);
      dp  <= ~(idx == 3'd3 || idx == 3'd5);
    end
  end

endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
Downstream display stage for the stopwatch counter block. Consumes the binary millisec/sec/min values and converts them to BCD with one shared sequential double-dabble engine. Drives a multiplexed 8-digit common-anode seven-segment display in the format MM.SS.mmm.

Parameters:
SCAN_DIV, 100000, clk cycles each digit slot is held (must be >= 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
millisec  input  10  binary milliseconds from counter (nominal 0..999)
sec  input  6  binary seconds (nominal 0..59)
min  input  6  binary minutes (nominal 0..59)
blank  input  1  1 = all digits dark; scanning and conversion continue
an  output  8  digit enables, active-low, one-hot-low
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low

Behaviour:
- Reset values (asynchronous, active-high):
  - an=8'hFF, seg=7'h7F, dp=1.
  - Scan counter=0, digit index=0, FSM=CAPTURE.
  - Display BCD register=0, so the first frame after reset shows 00.00.000.
- Conversion FSM (free-running): CAPTURE -> CONV_MS -> CONV_SEC -> CONV_MIN -> COMMIT -> CAPTURE.
- CAPTURE (1 cycle): snapshot all three inputs in the same cycle, clamped at capture:
  - millisec>999 -> 999
  - sec>59 -> 59
  - min>59 -> 59
- CONV_* (exactly 10 cycles each):
  - Field zero-extended to 10 bits, 12-bit BCD accumulator cleared on entry.
  - Each cycle: add 3 to every accumulator nibble >=5, then shift {bcd,bin} left by 1.
  - On exit, store the field's BCD into a shadow register: 3 digits for ms, 2 each for sec and min.
- COMMIT (1 cycle): copy all 7 shadow digits into the display register at once.
- Full period is 32 cycles. Commit occurs 31 cycles after capture.
- The display register never holds a mix of two captures. Input changes during conversion take effect only at the next CAPTURE.
- Scan:
  - Scan counter counts 0..SCAN_DIV-1.
  - On terminal count it wraps to 0 and digit index increments mod 8.
- Digit mapping, by digit index:
  - 0 = ms ones
  - 1 = ms tens
  - 2 = ms hundreds
  - 3 = sec ones
  - 4 = sec tens
  - 5 = min ones
  - 6 = min tens
  - 7 = unused slot: an=8'hFF, seg=7'h7F, dp=1
- Output timing:
  - an, seg and dp are registered, one cycle after the index change.
  - For index i<7: an = ~(1<<i), seg = decode(digit i).
  - dp=0 only on index 3 and index 5 (separators); otherwise dp=1.
- Segment decode, digit -> seg:
  - 0->40h, 1->79h, 2->24h, 3->30h, 4->19h
  - 5->12h, 6->02h, 7->78h, 8->00h, 9->10h
  - Any other nibble -> 7Fh (unreachable given clamping).
- blank=1: the next registered outputs are an=FFh, seg=7Fh, dp=1.
  - Digit index and FSM keep running.
  - Release resumes at the current index with no glitch.
- Reset mid-conversion: abandons the in-progress conversion, clears the display register, and restarts at CAPTURE.

Test Plan:
1. Reset (including reset asserted mid-conversion) -> an=FFh, seg=7Fh, dp=1 immediately. First lit frame shows 00.00.000 (seg=40h on indices 0..6).
2. SCAN_DIV=4, millisec=123, sec=45, min=7 held -> an sequence FEh,FDh,FBh,F7h,EFh,DFh,BFh,FFh, each held exactly 4 cycles. seg sequence 30h,24h,79h,12h,19h,78h,40h. dp=0 only with an=F7h and an=DFh.
3. Clamp: millisec=1023, sec=63, min=63 -> displayed digits 9,9,9,9,5,9,5 (seg=10h/12h), never 1023/63.
4. Coherency: values 111/11/11 held, then switched to 222/22/22 in cycle 10 of a conversion -> display register changes exactly once, directly from all-1s to all-2s, within 2 periods (64 cycles). No mixed digits are observed.
5. Blank: assert blank for 10 cycles mid-frame -> an=FFh, seg=7Fh, dp=1 throughout. After release, scanning resumes at the index given by the uninterrupted count.
6. Boundary values 999/59/59 -> 000/00/00 (counter wrap) -> display shows 59.59.999, then 00.00.000 within 64 cycles, with no intermediate values.
